// File: rtl/card_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// card_pkg : shared states, limits and card normalisation for card_dealer
// Rev 1.0
// ---------------------------------------------------------------------------
package card_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DEAL_P1 = 3'd1,
    DEAL_D1 = 3'd2,
    DEAL_P2 = 3'd3,
    DEAL_D2 = 3'd4,
    PLAYER  = 3'd5,
    DEALER  = 3'd6,
    DONE    = 3'd7
  } state_e;

  localparam logic [4:0] DEALER_STAND = 5'd17;
  localparam logic [4:0] BLACKJACK    = 5'd21;
  localparam logic [4:0] ACE_BONUS    = 5'd10;
  // An ace may only count high while the hard sum leaves room for the bonus.
  localparam logic [4:0] SOFT_LIMIT   = BLACKJACK - ACE_BONUS;

  function automatic logic [4:0] norm_card(input logic [3:0] card);
    logic [4:0] val;
    if (card == 4'd0)       val = 5'd1;
    else if (card > 4'd10)  val = 5'd10;
    else                    val = {1'b0, card};
    return val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hand_accum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hand_accum : one hand's hard sum, ace-seen flag and effective total
// Rev 1.0
// ---------------------------------------------------------------------------
module hand_accum
  import card_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       add_i,
  input  logic [3:0] card_i,
  output logic [4:0] hard_o,
  output logic       ace_o,
  output logic [4:0] total_o
);

  logic [4:0] hard_q, hard_d;
  logic       ace_q,  ace_d;
  logic [4:0] card_val;

  always_comb begin
    card_val = norm_card(card_i);
    hard_d   = hard_q;
    ace_d    = ace_q;
    if (clear_i) begin
      hard_d = '0;
      ace_d  = 1'b0;
    end else if (add_i) begin
      hard_d = hard_q + card_val;
      ace_d  = ace_q | (card_val == 5'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hard_q <= '0;
      ace_q  <= 1'b0;
    end else begin
      hard_q <= hard_d;
      ace_q  <= ace_d;
    end
  end

  assign hard_o  = hard_q;
  assign ace_o   = ace_q;
  assign total_o = (ace_q && (hard_q <= SOFT_LIMIT)) ? hard_q + ACE_BONUS : hard_q;

endmodule
`default_nettype wire

// File: rtl/card_dealer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// card_dealer : single-player blackjack round sequencer with result flags
// Rev 1.0
// ---------------------------------------------------------------------------
module card_dealer
  import card_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] card_in,
  input  logic       start,
  input  logic       hit,
  input  logic       stand,
  output logic [4:0] player_total,
  output logic [4:0] dealer_total,
  output logic [2:0] phase,
  output logic       win,
  output logic       lose,
  output logic       push
);

  state_e     state_q, state_d;
  logic       win_q, win_d, lose_q, lose_d, push_q, push_d;
  logic       clear, p_add, d_add;
  logic [4:0] p_hard, p_total, d_hard, d_total;
  logic       p_ace, d_ace;
  logic       unused_ace;

  hand_accum u_player (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .add_i   (p_add),
    .card_i  (card_in),
    .hard_o  (p_hard),
    .ace_o   (p_ace),
    .total_o (p_total)
  );

  hand_accum u_dealer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .add_i   (d_add),
    .card_i  (card_in),
    .hard_o  (d_hard),
    .ace_o   (d_ace),
    .total_o (d_total)
  );

  assign unused_ace = &{1'b0, p_ace, d_ace};

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    lose_d  = lose_q;
    push_d  = push_q;
    clear   = 1'b0;
    p_add   = 1'b0;
    d_add   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          clear   = 1'b1;
          win_d   = 1'b0;
          lose_d  = 1'b0;
          push_d  = 1'b0;
          state_d = DEAL_P1;
        end
      end
      DEAL_P1: begin p_add = 1'b1; state_d = DEAL_D1; end
      DEAL_D1: begin d_add = 1'b1; state_d = DEAL_P2; end
      DEAL_P2: begin p_add = 1'b1; state_d = DEAL_D2; end
      DEAL_D2: begin
        d_add   = 1'b1;
        state_d = (p_total == BLACKJACK) ? DEALER : PLAYER;
      end
      PLAYER: begin
        // Bust and 21 are judged on the registered hand, i.e. the cycle after a hit.
        if (p_hard > BLACKJACK) begin
          lose_d  = 1'b1;
          state_d = DONE;
        end else if ((p_total == BLACKJACK) || stand) begin
          state_d = DEALER;
        end else if (hit) begin
          p_add = 1'b1;
        end
      end
      DEALER: begin
        if (d_total < DEALER_STAND) begin
          d_add = 1'b1;
        end else begin
          state_d = DONE;
          if ((d_hard > BLACKJACK) || (p_total > d_total)) win_d  = 1'b1;
          else if (p_total < d_total)                      lose_d = 1'b1;
          else                                             push_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      push_q  <= push_d;
    end
  end

  assign player_total = p_total;
  assign dealer_total = d_total;
  assign phase        = state_q;
  assign win          = win_q;
  assign lose         = lose_q;
  assign push         = push_q;

endmodule
`default_nettype wire
